// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch FSM state encodings and default datapath widths.
package cpu_defs;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 32;
  localparam int WAIT_MAX_DEF = 15;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_ISSUE = 3'd1,
    FETCH_WAIT  = 3'd2,
    FETCH_HOLD  = 3'd3,
    FETCH_REDIR = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_timer.sv
// Memory wait counter: cleared on start, advanced on tick, flags the last allowed wait cycle.
module fetch_timer
  import cpu_defs::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic tick,
  output logic expired
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_MAX - 1);

  logic [CNT_W-1:0] wcnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      wcnt <= '0;
    end else if (start) begin
      wcnt <= '0;
    end else if (tick) begin
      wcnt <= wcnt + CNT_W'(1);
    end
  end

  assign expired = (wcnt == LAST);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: issues word reads at the PC, holds the result for decode,
// and pulses the PC register for sequential advance or branch redirect.
module fetch_ctrl
  import cpu_defs::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc_q,
  output logic              pc_en,
  output logic              pc_inc,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_target,
  output logic              fetch_err
);

  fetch_state_t      state_q, state_d;
  logic              flush, flush_d;
  logic              pc_en_d, pc_inc_d, mem_rd_d, ir_valid_d, err_d;
  logic [ADDR_W-1:0] pc_next_d, mem_addr_d;
  logic [DATA_W-1:0] ir_out_d;
  logic              tmr_start, tmr_tick, tmr_expired;

  fetch_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk     (clk),
    .clr     (clr),
    .start   (tmr_start),
    .tick    (tmr_tick),
    .expired (tmr_expired)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d    = state_q;
    flush_d    = flush;
    pc_en_d    = 1'b0;
    pc_inc_d   = 1'b0;
    pc_next_d  = pc_next;
    mem_addr_d = mem_addr;
    mem_rd_d   = mem_rd;
    ir_out_d   = ir_out;
    ir_valid_d = ir_valid;
    err_d      = fetch_err;
    tmr_start  = 1'b0;
    tmr_tick   = 1'b0;

    case (state_q)
      FETCH_IDLE: begin
        if (run && !fetch_err) begin
          state_d = FETCH_ISSUE;
        end
      end

      FETCH_ISSUE: begin
        mem_addr_d = pc_q;
        mem_rd_d   = 1'b1;
        tmr_start  = 1'b1;
        state_d    = FETCH_WAIT;
        if (br_take) begin
          pc_next_d = br_target;
          flush_d   = 1'b1;
        end
      end

      FETCH_WAIT: begin
        tmr_tick = 1'b1;
        if (!mem_ack && tmr_expired) begin
          mem_rd_d = 1'b0;
          err_d    = 1'b1;
          flush_d  = 1'b0;
          state_d  = FETCH_IDLE;
        end else if (mem_ack && (flush || br_take)) begin
          // A branch arriving with the ack wins: the returned word is stale.
          mem_rd_d = 1'b0;
          pc_en_d  = 1'b1;
          pc_inc_d = 1'b0;
          flush_d  = 1'b0;
          if (br_take) begin
            pc_next_d = br_target;
          end
          state_d = FETCH_REDIR;
        end else if (mem_ack) begin
          ir_out_d   = mem_rdata;
          ir_valid_d = 1'b1;
          mem_rd_d   = 1'b0;
          pc_en_d    = 1'b1;
          pc_inc_d   = 1'b1;
          state_d    = FETCH_HOLD;
        end else if (br_take) begin
          pc_next_d = br_target;
          flush_d   = 1'b1;
        end
      end

      FETCH_HOLD: begin
        if (br_take) begin
          ir_valid_d = 1'b0;
          pc_next_d  = br_target;
          pc_en_d    = 1'b1;
          pc_inc_d   = 1'b0;
          state_d    = FETCH_REDIR;
        end else if (ir_valid && ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = run ? FETCH_ISSUE : FETCH_IDLE;
        end
      end

      FETCH_REDIR: begin
        state_d = run ? FETCH_ISSUE : FETCH_IDLE;
      end

      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= FETCH_IDLE;
      flush     <= 1'b0;
      pc_en     <= 1'b0;
      pc_inc    <= 1'b0;
      pc_next   <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      ir_out    <= '0;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush     <= flush_d;
      pc_en     <= pc_en_d;
      pc_inc    <= pc_inc_d;
      pc_next   <= pc_next_d;
      mem_addr  <= mem_addr_d;
      mem_rd    <= mem_rd_d;
      ir_out    <= ir_out_d;
      ir_valid  <= ir_valid_d;
      fetch_err <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and memory models around the DUT, directed scenarios,
// then randomized traffic checked by an instruction-stream scoreboard.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        clr, run, mem_ack, ir_ready, br_take;
  logic [31:0] pc_q, pc_next, mem_addr, mem_rdata, ir_out, br_target;
  logic        pc_en, pc_inc, mem_rd, ir_valid, fetch_err;

  int checks = 0;
  int errors = 0;
  int n_consumed = 0;
  int inc_cnt = 0;
  int ld_cnt = 0;
  int dead_seen = 0;

  logic        mem_auto = 1'b0;
  int          lat_max = 0;
  int          mlat = 0;
  int          mwait = 0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_q[$];

  fetch_ctrl #(.DATA_W(32), .ADDR_W(32), .WAIT_MAX(15)) dut (
    .clk       (clk),
    .clr       (clr),
    .run       (run),
    .pc_q      (pc_q),
    .pc_en     (pc_en),
    .pc_inc    (pc_inc),
    .pc_next   (pc_next),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir_out    (ir_out),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .br_take   (br_take),
    .br_target (br_target),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hA0 + a;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic br, input logic [31:0] tgt);
    run       = r;
    ir_ready  = rdy;
    br_take   = br;
    br_target = tgt;
  endtask

  task automatic doClear();
    clr = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    clr = 1'b0;
  endtask

  task automatic waitMemRd(input string name);
    int n = 0;
    while (!mem_rd && n < 20) begin
      step();
      n++;
    end
    if (!mem_rd) checkOutput(name, 64'(mem_rd), 64'd1);
  endtask

  task automatic waitIrValid(input string name);
    int n = 0;
    while (!ir_valid && n < 40) begin
      step();
      n++;
    end
    if (!ir_valid) checkOutput(name, 64'(ir_valid), 64'd1);
  endtask

  // PC register the DUT drives.
  always @(posedge clk) begin
    if (clr) pc_q <= '0;
    else if (pc_en) pc_q <= pc_inc ? pc_q + 32'd1 : pc_next;
  end

  // Instruction memory with random response latency.
  always @(posedge clk) begin
    #2;
    if (mem_auto) begin
      mem_ack = 1'b0;
      if (mem_rd && !clr) begin
        if (mwait >= mlat) begin
          mem_ack   = 1'b1;
          mem_rdata = memWord(mem_addr);
          mwait     = 0;
          mlat      = $urandom_range(0, lat_max);
        end else begin
          mwait++;
        end
      end else begin
        mwait = 0;
      end
    end
  end

  // Reference model: decode sees words from consecutive addresses; a redirect restarts at the target.
  always @(negedge clk) begin
    if (clr) begin
      exp_q.delete();
      exp_addr = '0;
      exp_q.push_back(memWord(exp_addr));
    end else if (br_take && (mem_rd || ir_valid)) begin
      exp_q.delete();
      exp_addr = br_target;
      exp_q.push_back(memWord(exp_addr));
    end else if (ir_valid && ir_ready) begin
      exp_addr = exp_addr + 32'd1;
      exp_q.push_back(memWord(exp_addr));
    end
  end

  // Monitor: every instruction decode accepts must match the head of the expected stream.
  always @(negedge clk) begin
    if (!clr) begin
      if (ir_valid && ir_out == 32'hDEAD) dead_seen++;
      if (pc_en) begin
        if (pc_inc) inc_cnt++;
        else ld_cnt++;
      end
      if (ir_valid && ir_ready && !br_take) begin
        if (exp_q.size() == 0) checkOutput("sb_empty", 64'(exp_q.size()), 64'd1);
        else checkOutput("sb_ir_out", 64'(ir_out), 64'(exp_q.pop_front()));
        n_consumed++;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_c, base_i, base_l, n;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    doClear();

    // Reset values
    checkOutput("rst_pc_en", 64'(pc_en), 64'd0);
    checkOutput("rst_pc_inc", 64'(pc_inc), 64'd0);
    checkOutput("rst_pc_next", 64'(pc_next), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_mem_rd", 64'(mem_rd), 64'd0);
    checkOutput("rst_ir_out", 64'(ir_out), 64'd0);
    checkOutput("rst_ir_valid", 64'(ir_valid), 64'd0);
    checkOutput("rst_fetch_err", 64'(fetch_err), 64'd0);

    // 1: sequential fetch, zero-wait memory, then stop
    $display("[TB] sequential fetch");
    mem_auto = 1'b1;
    lat_max  = 0;
    base_c = n_consumed; base_i = inc_cnt; base_l = ld_cnt;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    checkOutput("t1_idle_to_issue", 64'(ir_valid | mem_rd), 64'd0);
    step();
    checkOutput("t1_mem_rd", 64'(mem_rd), 64'd1);
    checkOutput("t1_mem_addr", 64'(mem_addr), 64'd0);
    step();
    checkOutput("t1_ir_valid", 64'(ir_valid), 64'd1);
    checkOutput("t1_ir_out", 64'(ir_out), 64'hA0);
    checkOutput("t1_pc_en", 64'(pc_en), 64'd1);
    checkOutput("t1_pc_inc", 64'(pc_inc), 64'd1);
    n = 0;
    while (n_consumed - base_c < 3 && n < 40) begin
      step();
      n++;
    end
    checkOutput("t1_progress", 64'(n_consumed - base_c >= 3), 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (10) step();
    checkOutput("t1_no_load_pulse", 64'(ld_cnt - base_l), 64'd0);
    checkOutput("t1_inc_per_instr", 64'(inc_cnt - base_i), 64'(n_consumed - base_c));
    checkOutput("t1_stopped", 64'(ir_valid | mem_rd), 64'd0);

    // 2: backpressure
    $display("[TB] backpressure");
    doClear();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    waitIrValid("t2_wait_valid");
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2_hold_valid", 64'(ir_valid), 64'd1);
      checkOutput("t2_hold_ir_out", 64'(ir_out), 64'hA0);
      checkOutput("t2_no_new_rd", 64'(mem_rd), 64'd0);
      step();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t2_accepted", 64'(ir_valid), 64'd0);
    checkOutput("t2_rd_not_yet", 64'(mem_rd), 64'd0);
    step();
    checkOutput("t2_next_rd", 64'(mem_rd), 64'd1);
    checkOutput("t2_next_addr", 64'(mem_addr), 64'd1);
    step();
    checkOutput("t2_second_word", 64'(ir_out), 64'hA1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (6) step();

    // 3: branch while holding an instruction
    $display("[TB] branch in HOLD");
    doClear();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    waitIrValid("t3_wait_valid");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t3_valid_drop", 64'(ir_valid), 64'd0);
    checkOutput("t3_pc_en", 64'(pc_en), 64'd1);
    checkOutput("t3_pc_inc", 64'(pc_inc), 64'd0);
    checkOutput("t3_pc_next", 64'(pc_next), 64'h40);
    waitMemRd("t3_wait_rd");
    checkOutput("t3_redir_addr", 64'(mem_addr), 64'h40);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    waitIrValid("t3_wait_target");
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (6) step();

    // 4: branch during WAIT, stale ack arrives later
    $display("[TB] branch in WAIT");
    doClear();
    mem_auto = 1'b0;
    mem_ack  = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    waitMemRd("t4_wait_rd");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h20);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    step();
    checkOutput("t4_still_waiting", 64'(mem_rd), 64'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD;
    step();
    mem_ack = 1'b0;
    checkOutput("t4_dropped", 64'(ir_valid), 64'd0);
    checkOutput("t4_pc_en", 64'(pc_en), 64'd1);
    checkOutput("t4_pc_inc", 64'(pc_inc), 64'd0);
    checkOutput("t4_pc_next", 64'(pc_next), 64'h20);
    mem_auto = 1'b1;
    waitMemRd("t4_wait_redir");
    checkOutput("t4_redir_addr", 64'(mem_addr), 64'h20);
    repeat (6) step();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (6) step();
    checkOutput("t4_no_dead", 64'(dead_seen), 64'd0);

    // 5: memory timeout
    $display("[TB] timeout");
    doClear();
    mem_auto = 1'b0;
    mem_ack  = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    waitMemRd("t5_wait_rd");
    n = 0;
    while (mem_rd && n < 40) begin
      n++;
      step();
    end
    checkOutput("t5_rd_cycles", 64'(n), 64'd15);
    checkOutput("t5_err_set", 64'(fetch_err), 64'd1);
    repeat (5) step();
    checkOutput("t5_run_ignored", 64'(mem_rd), 64'd0);
    checkOutput("t5_err_sticky", 64'(fetch_err), 64'd1);
    doClear();
    checkOutput("t5_err_cleared", 64'(fetch_err), 64'd0);

    // 6: clear mid-WAIT together with a branch, then a late ack
    $display("[TB] clear mid-fetch");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    waitMemRd("t6_wait_rd");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h77);
    step();
    clr = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h55);
    step();
    clr = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("t6_mem_rd", 64'(mem_rd), 64'd0);
    checkOutput("t6_pc_next", 64'(pc_next), 64'd0);
    checkOutput("t6_pc_en", 64'(pc_en), 64'd0);
    checkOutput("t6_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("t6_ir_valid", 64'(ir_valid), 64'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234;
    step();
    mem_ack = 1'b0;
    checkOutput("t6_late_ack_valid", 64'(ir_valid), 64'd0);
    checkOutput("t6_late_ack_ir", 64'(ir_out), 64'd0);
    checkOutput("t6_late_ack_pc_en", 64'(pc_en), 64'd0);
    step();
    checkOutput("t6_idle_rd", 64'(mem_rd), 64'd0);

    // Randomized traffic: latency, backpressure, run toggling and branches in WAIT/HOLD
    $display("[TB] random traffic");
    doClear();
    mem_auto = 1'b1;
    lat_max  = 4;
    base_c   = n_consumed;
    begin
      logic run_r;
      run_r = 1'b1;
      for (int i = 0; i < 1500; i++) begin
        logic brk;
        brk = (mem_rd || ir_valid) && ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 19) == 0) run_r = ~run_r;
        applyStimulus(run_r, 1'($urandom_range(0, 1)), brk, 32'($urandom_range(0, 255)));
        step();
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (20) step();
    checkOutput("rand_progress", 64'(n_consumed - base_c > 50), 64'd1);
    checkOutput("rand_no_err", 64'(fetch_err), 64'd0);
    checkOutput("rand_no_dead", 64'(dead_seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
